// File: rtl/pix_line_fetch.sv
// Ping-pong line fetcher: streams one line from banked external pixel memory into the back buffer while video reads the front buffer.
// Optional macro PIX_LINE_FETCH_UNDERRUN_CNT_EN adds a saturating 8-bit underrun counter; without it underrun_cnt is tied to 0.
//
// state | meaning
// IDLE  | no fetch pending, waiting for fetch_req
// FETCH | presenting one address per cycle, LINE_PIX in total
// DRAIN | waiting FETCH_LAT cycles for in-flight pixels
// DONE  | back buffer complete, waiting for swap
module pix_line_fetch #(
  parameter int PIX_W     = 4,
  parameter int ADDR_W    = 8,
  parameter int BANK_W    = 1,
  parameter int LINE_PIX  = 160,
  parameter int FETCH_LAT = 2,
  localparam int X_W      = $clog2(LINE_PIX)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     fetch_req,
  input  logic [BANK_W+ADDR_W-1:0] fetch_base,
  input  logic                     swap,
  input  logic                     rd_en,
  input  logic [X_W-1:0]           rd_x,
  output logic [PIX_W-1:0]         rd_pix,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BANK_W-1:0]        mem_bank,
  input  logic [PIX_W-1:0]         mem_pix_in,
  output logic                     fetch_busy,
  output logic                     fetch_done,
  output logic                     underrun,
  input  logic                     underrun_clr,
  output logic [7:0]               underrun_cnt
);

  localparam int A_W = BANK_W + ADDR_W;
  localparam int D_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [X_W-1:0] CNT_LAST   = X_W'(LINE_PIX - 1);
  localparam logic [D_W-1:0] DRAIN_LOAD = D_W'(FETCH_LAT - 1);
  localparam logic [X_W:0]   X_LIMIT    = (X_W + 1)'(LINE_PIX);

  logic [1:0]       state;
  logic             front;
  logic [A_W-1:0]   addr_q;
  logic [X_W-1:0]   cnt;
  logic [D_W-1:0]   drain_cnt;
  logic             start;
  logic             under_ev;
  logic             wr_vld;
  logic [X_W-1:0]   wr_idx;
  logic [PIX_W-1:0] line_mem [2][LINE_PIX];

  assign start      = fetch_req & ena & ((state == S_IDLE) | (state == S_DONE));
  assign under_ev   = swap & (state != S_DONE);
  assign fetch_busy = (state == S_FETCH) | (state == S_DRAIN);
  assign fetch_done = (state == S_DONE);
  assign {mem_bank, mem_addr} = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      front     <= 1'b0;
      addr_q    <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
    end else begin
      if (swap && state == S_DONE) front <= ~front;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_FETCH;
            addr_q <= fetch_base;
            cnt    <= '0;
          end else if (state == S_DONE && swap) begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          // the last address stays on the bus; it is not advanced past the line
          if (cnt == CNT_LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else begin
            cnt    <= cnt + 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) state <= S_DONE;
          else drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Issue index travels alongside the memory latency so pixel k lands in entry k.
  if (FETCH_LAT == 1) begin : g_lat1
    assign wr_vld = (state == S_FETCH);
    assign wr_idx = cnt;
  end else begin : g_latn
    logic [FETCH_LAT-2:0] vld_q;
    logic [X_W-1:0]       idx_q [FETCH_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < FETCH_LAT - 1; i++) idx_q[i] <= '0;
      end else begin
        vld_q[0] <= (state == S_FETCH);
        idx_q[0] <= cnt;
        for (int i = 1; i < FETCH_LAT - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign wr_vld = vld_q[FETCH_LAT-2];
    assign wr_idx = idx_q[FETCH_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (wr_vld) line_mem[~front][wr_idx] <= mem_pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pix <= '0;
    end else if (rd_en) begin
      rd_pix <= ({1'b0, rd_x} < X_LIMIT) ? line_mem[front][rd_x] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun <= 1'b0;
    else if (underrun_clr) underrun <= 1'b0;
    else if (under_ev) underrun <= 1'b1;
  end

`ifdef PIX_LINE_FETCH_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else if (underrun_clr) ucnt_q <= '0;
    else if (under_ev && ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 1'b1;
  end

  assign underrun_cnt = ucnt_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_pix_line_fetch.sv
// Scoreboard bench for pix_line_fetch: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_pix_line_fetch;

`ifdef PIX_LINE_FETCH_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int SEL_ADDR = 0;
  localparam int SEL_BUSY = 1;
  localparam int SEL_DONE = 2;
  localparam int SEL_UND  = 3;
  localparam int SEL_UCNT = 4;
  localparam int SEL_PIX  = 5;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       fetch_req;
  logic [8:0] fetch_base;
  logic       swap;
  logic       rd_en;
  logic [7:0] rd_x;
  logic [3:0] rd_pix;
  logic [7:0] mem_addr;
  logic [0:0] mem_bank;
  logic [3:0] mem_pix_in;
  logic       fetch_busy;
  logic       fetch_done;
  logic       underrun;
  logic       underrun_clr;
  logic [7:0] underrun_cnt;

  int    n_total = 0;
  int    n_pass  = 0;
  int    pix_q [$];
  int    sel_q [$];
  int    val_q [$];
  string nm_q  [$];
  logic  rd_seen = 1'b0;
  logic  [3:0] mem_d1 = 4'h0;

  pix_line_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .fetch_req    (fetch_req),
    .fetch_base   (fetch_base),
    .swap         (swap),
    .rd_en        (rd_en),
    .rd_x         (rd_x),
    .rd_pix       (rd_pix),
    .mem_addr     (mem_addr),
    .mem_bank     (mem_bank),
    .mem_pix_in   (mem_pix_in),
    .fetch_busy   (fetch_busy),
    .fetch_done   (fetch_done),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External memory: data = addr[3:0], two-cycle latency from address to sample edge.
  always @(posedge clk) mem_d1 <= mem_addr[3:0];
  assign mem_pix_in = mem_d1;

  always @(posedge clk) rd_seen <= rd_en;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic int actual(input int sel);
    case (sel)
      SEL_ADDR: actual = int'({mem_bank, mem_addr});
      SEL_BUSY: actual = int'(fetch_busy);
      SEL_DONE: actual = int'(fetch_done);
      SEL_UND:  actual = int'(underrun);
      SEL_UCNT: actual = int'(underrun_cnt);
      default:  actual = int'(rd_pix);
    endcase
  endfunction

  always @(negedge clk) begin
    int e;
    if (rd_seen) begin
      if (pix_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_pix_unexpected: got %0h required no read", rd_pix);
      end else begin
        e = pix_q.pop_front();
        check("rd_pix", int'(rd_pix), e);
      end
    end
    while (sel_q.size() > 0) begin
      check(nm_q.pop_front(), actual(sel_q[0]), val_q.pop_front());
      void'(sel_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_s(input int sel, input int val, input string nm);
    sel_q.push_back(sel);
    val_q.push_back(val);
    nm_q.push_back(nm);
  endtask

  task automatic rd(input int x, input int val);
    rd_en = 1'b1;
    rd_x  = 8'(x);
    pix_q.push_back(val);
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic exp_reset_vals(input string tag);
    exp_s(SEL_ADDR, 0, {tag, "_addr"});
    exp_s(SEL_BUSY, 0, {tag, "_busy"});
    exp_s(SEL_DONE, 0, {tag, "_done"});
    exp_s(SEL_UND,  0, {tag, "_underrun"});
    exp_s(SEL_UCNT, 0, {tag, "_ucnt"});
    exp_s(SEL_PIX,  0, {tag, "_rd_pix"});
  endtask

  task automatic start_fetch(input logic [8:0] base, input logic with_swap);
    fetch_req  = 1'b1;
    fetch_base = base;
    swap       = with_swap;
    cyc();
    fetch_req  = 1'b0;
    swap       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; fetch_req = 1'b0; fetch_base = '0; swap = 1'b0;
    rd_en = 1'b0; rd_x = '0; underrun_clr = 1'b0;
    cyc(); cyc();
    exp_reset_vals("reset");
    cyc();
    rst_n = 1'b1;
    cyc();

    // ena low blocks fetch_req
    ena = 1'b0;
    start_fetch(9'h0FE, 1'b0);
    exp_s(SEL_BUSY, 0, "ena_low_busy");
    ena = 1'b1;
    cyc();

    // fetch 1: base 0x0FE, bank carry at k=2
    start_fetch(9'h0FE, 1'b0);
    exp_s(SEL_ADDR, 9'h0FE, "f1_addr0");
    exp_s(SEL_BUSY, 1, "f1_busy0");
    for (int k = 1; k <= 162; k++) begin
      cyc();
      if (k == 1) exp_s(SEL_ADDR, 9'h0FF, "f1_addr1");
      if (k == 2) exp_s(SEL_ADDR, 9'h100, "f1_addr2");
      if (k == 161) begin
        exp_s(SEL_DONE, 0, "f1_done161");
        exp_s(SEL_BUSY, 1, "f1_busy161");
      end
      if (k == 162) begin
        exp_s(SEL_DONE, 1, "f1_done162");
        exp_s(SEL_BUSY, 0, "f1_busy162");
        exp_s(SEL_ADDR, 9'h19D, "f1_addr_hold");
      end
    end
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    exp_s(SEL_DONE, 0, "f1_swap_done");
    exp_s(SEL_UND,  0, "f1_swap_no_underrun");
    rd(0, 4'hE);
    rd(159, 4'hD);
    rd(200, 4'h0);
    rd(1, 4'hF);

    // fetch 2: base 0x1F8 wraps to 0; underrun swap at cycle 50
    start_fetch(9'h1F8, 1'b0);
    for (int k = 1; k <= 162; k++) begin
      cyc();
      if (k == 7) exp_s(SEL_ADDR, 9'h1FF, "f2_addr7");
      if (k == 8) exp_s(SEL_ADDR, 9'h000, "f2_addr_wrap");
      if (k == 49) swap = 1'b1;
      if (k == 50) begin
        swap = 1'b0;
        exp_s(SEL_UND,  1, "f2_underrun");
        exp_s(SEL_UCNT, CNT_EN ? 1 : 0, "f2_ucnt");
        exp_s(SEL_BUSY, 1, "f2_busy_after_underrun");
        rd_en = 1'b1; rd_x = 8'd0; pix_q.push_back(4'hE);
      end
      if (k == 51) rd_en = 1'b0;
      if (k == 161) exp_s(SEL_DONE, 0, "f2_done161");
      if (k == 162) exp_s(SEL_DONE, 1, "f2_done162");
    end

    // swap and fetch_req together in DONE, then abort with reset at cycle 80
    start_fetch(9'h050, 1'b1);
    exp_s(SEL_BUSY, 1, "f3_busy0");
    exp_s(SEL_DONE, 0, "f3_done0");
    exp_s(SEL_ADDR, 9'h050, "f3_addr0");
    rd_en = 1'b1; rd_x = 8'd0; pix_q.push_back(4'h8);
    for (int k = 1; k <= 80; k++) begin
      cyc();
      if (k == 1) begin rd_x = 8'd8; pix_q.push_back(4'h0); end
      if (k == 2) rd_en = 1'b0;
      if (k == 9) begin fetch_req = 1'b1; fetch_base = 9'h1AA; end
      if (k == 10) fetch_req = 1'b0;
      if (k == 11) begin
        exp_s(SEL_ADDR, 9'h05B, "f3_req_ignored_addr");
        exp_s(SEL_BUSY, 1, "f3_busy11");
      end
      if (k == 78) begin rd_en = 1'b1; rd_x = 8'd7; pix_q.push_back(4'hF); end
      if (k == 79) rd_en = 1'b0;
      if (k == 80) begin
        rst_n = 1'b0;
        exp_reset_vals("abort");
      end
    end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // fetch 4 after reset completes normally
    start_fetch(9'h0FE, 1'b0);
    for (int k = 1; k <= 162; k++) begin
      cyc();
      if (k == 161) exp_s(SEL_DONE, 0, "f4_done161");
      if (k == 162) exp_s(SEL_DONE, 1, "f4_done162");
    end
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    rd(0, 4'hE);
    rd(159, 4'hD);

    // 300 underruns in IDLE, then clear, then clear coincident with underrun
    swap = 1'b1;
    repeat (300) cyc();
    swap = 1'b0;
    exp_s(SEL_UND,  1, "sat_underrun");
    exp_s(SEL_UCNT, CNT_EN ? 255 : 0, "sat_ucnt");
    cyc();
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    exp_s(SEL_UND,  0, "clr_underrun");
    exp_s(SEL_UCNT, 0, "clr_ucnt");
    cyc();
    swap = 1'b1; underrun_clr = 1'b1;
    cyc();
    swap = 1'b0; underrun_clr = 1'b0;
    exp_s(SEL_UND,  0, "clr_prio_underrun");
    exp_s(SEL_UCNT, 0, "clr_prio_ucnt");
    cyc();
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    exp_s(SEL_UND,  1, "post_clr_underrun");
    exp_s(SEL_UCNT, CNT_EN ? 1 : 0, "post_clr_ucnt");
    rd(0, 4'hE);

    cyc(); cyc();
    check("queues_drained", pix_q.size() + sel_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
